cla_shared_adder_sched: RTL and testbench

Round-robin scheduler that shares one 4-bit carry-lookahead adder slice between two requesters. Each request adds two 4·NIB-bit operands plus a carry-in, least-significant nibble first, one nibble per clock. The carry is chained through a registered carry flop. The block sits between two arithmetic clients and the single CLA slice, trading one wide adder for NIB cycles of latency.

---
 rtl/cla_shared_adder_sched.sv | 141 ++++++++++++++
 tb/tb_cla_shared_adder_sched.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_shared_adder_sched.sv
// Two-requester round-robin front end for a single 4-bit carry-lookahead slice.
// Each granted operation is summed one nibble per clock, LSB nibble first, with a registered carry.

module cla_shared_adder_sched_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] sum,
    output logic       co
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        sum  = p ^ c;
    end
endmodule

module cla_shared_adder_sched #(
    parameter  int NIB = 4,
    localparam int W   = 4 * NIB,
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         c0,
    output logic         gnt0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    input  logic         c1,
    output logic         gnt1,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         id,
    output logic         done,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  op_a, op_b, acc, acc_nx;
    logic [W-1:0]  sh_a, sh_b, nib_mask;
    logic [CW-1:0] cnt;
    logic          carry, rr, own, win, any_req, last;
    logic [3:0]    sn;
    logic          co;

    // rr only breaks ties; a lone requester always wins
    always_comb begin
        any_req = req0 | req1;
        win     = (req0 && req1) ? rr : req1;
        last    = (cnt == CW'(NIB - 1));
    end

    // Select the active nibble by shifting rather than an indexed slice, so
    // non-power-of-two NIB never forms an out-of-range select.
    always_comb begin
        sh_a     = op_a >> {cnt, 2'b00};
        sh_b     = op_b >> {cnt, 2'b00};
        nib_mask = W'(4'hF) << {cnt, 2'b00};
        acc_nx   = (acc & ~nib_mask) | (W'(sn) << {cnt, 2'b00});
    end

    cla_shared_adder_sched_cla4 u_cla (
        .a  (sh_a[3:0]),
        .b  (sh_b[3:0]),
        .ci (carry),
        .sum(sn),
        .co (co)
    );

    always_comb begin
        state_nx = state;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        done     = (state == DONE);
        busy     = (state != IDLE);
        case (state)
            IDLE: if (any_req) begin
                gnt0     = ~win;
                gnt1     = win;
                state_nx = RUN;
            end
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            rr    <= 1'b0;
            own   <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            id    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (any_req) begin
                    op_a  <= win ? a1 : a0;
                    op_b  <= win ? b1 : b0;
                    carry <= win ? c1 : c0;
                    own   <= win;
                    rr    <= ~win;
                    cnt   <= '0;
                end
                RUN: begin
                    acc   <= acc_nx;
                    carry <= co;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        s    <= acc_nx;
                        cout <= co;
                        id   <= own;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_shared_adder_sched.sv
// Directed bench for cla_shared_adder_sched: a NIB=4 and a NIB=1 instance, each
// checked every cycle against a cycle-count/arithmetic model plus literal results.

module tb_cla_shared_adder_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req0_v, req1_v, c0_v, c1_v;
    logic [15:0] a0_v[2], b0_v[2], a1_v[2], b1_v[2];
    logic [1:0]  gnt0_v, gnt1_v, cout_v, id_v, done_v, busy_v;
    logic [15:0] s_a;
    logic [3:0]  s_b;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    cla_shared_adder_sched #(.NIB(4)) dut_a (
        .clk(clk), .rst(rst),
        .req0(req0_v[0]), .a0(a0_v[0]), .b0(b0_v[0]), .c0(c0_v[0]), .gnt0(gnt0_v[0]),
        .req1(req1_v[0]), .a1(a1_v[0]), .b1(b1_v[0]), .c1(c1_v[0]), .gnt1(gnt1_v[0]),
        .s(s_a), .cout(cout_v[0]), .id(id_v[0]), .done(done_v[0]), .busy(busy_v[0])
    );

    cla_shared_adder_sched #(.NIB(1)) dut_b (
        .clk(clk), .rst(rst),
        .req0(req0_v[1]), .a0(a0_v[1][3:0]), .b0(b0_v[1][3:0]), .c0(c0_v[1]), .gnt0(gnt0_v[1]),
        .req1(req1_v[1]), .a1(a1_v[1][3:0]), .b1(b1_v[1][3:0]), .c1(c1_v[1]), .gnt1(gnt1_v[1]),
        .s(s_b), .cout(cout_v[1]), .id(id_v[1]), .done(done_v[1]), .busy(busy_v[1])
    );

    function automatic int nib_of(int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic logic [15:0] f_mask(int nib);
        return 16'((32'd1 << (4 * nib)) - 32'd1);
    endfunction

    function automatic logic f_win(logic r0, logic r1, logic rr);
        return (r0 && r1) ? rr : r1;
    endfunction

    // Full-width sum of the masked operands; bit 4*nib is the carry-out.
    function automatic logic [16:0] f_sum(int nib, logic [15:0] a, logic [15:0] b, logic c);
        logic [15:0] m;
        m = f_mask(nib);
        return {1'b0, a & m} + {1'b0, b & m} + {16'b0, c};
    endfunction

    function automatic logic [15:0] s_of(int k);
        return (k == 0) ? s_a : {12'b0, s_b};
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %h want %h at cycle %0d", nm, k, act, exp, cyc_cnt);
        end
    endtask

    // Model: m_cyc counts cycles since the grant (0 = idle, 1..nib = run, nib+1 = done).
    int          m_cyc[2];
    logic        m_rr[2], m_co[2], m_id[2], m_pid[2];
    logic [15:0] m_s[2];
    logic [16:0] m_pend[2];

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_cyc[k] <= 0;
                m_rr[k]  <= 1'b0;
                m_s[k]   <= '0;
                m_co[k]  <= 1'b0;
                m_id[k]  <= 1'b0;
                m_pid[k] <= 1'b0;
                m_pend[k] <= '0;
            end else if (m_cyc[k] == 0) begin
                if (req0_v[k] | req1_v[k]) begin
                    m_pid[k]  <= f_win(req0_v[k], req1_v[k], m_rr[k]);
                    m_rr[k]   <= !f_win(req0_v[k], req1_v[k], m_rr[k]);
                    m_pend[k] <= f_win(req0_v[k], req1_v[k], m_rr[k])
                               ? f_sum(nib_of(k), a1_v[k], b1_v[k], c1_v[k])
                               : f_sum(nib_of(k), a0_v[k], b0_v[k], c0_v[k]);
                    m_cyc[k]  <= 1;
                end
            end else if (m_cyc[k] == nib_of(k)) begin
                m_cyc[k] <= nib_of(k) + 1;
                m_s[k]   <= m_pend[k][15:0] & f_mask(nib_of(k));
                m_co[k]  <= m_pend[k][4 * nib_of(k)];
                m_id[k]  <= m_pid[k];
            end else if (m_cyc[k] == nib_of(k) + 1) begin
                m_cyc[k] <= 0;
            end else begin
                m_cyc[k] <= m_cyc[k] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("gnt0", k, gnt0_v[k], (m_cyc[k] == 0) && (req0_v[k] | req1_v[k])
                                      && !f_win(req0_v[k], req1_v[k], m_rr[k]));
            chk("gnt1", k, gnt1_v[k], (m_cyc[k] == 0) && (req0_v[k] | req1_v[k])
                                      && f_win(req0_v[k], req1_v[k], m_rr[k]));
            chk("busy", k, busy_v[k], m_cyc[k] != 0);
            chk("done", k, done_v[k], m_cyc[k] == nib_of(k) + 1);
            chk("s",    k, s_of(k),   m_s[k]);
            chk("cout", k, cout_v[k], m_co[k]);
            chk("id",   k, id_v[k],   m_id[k]);
        end
    end

    task automatic wait_gnt(input int k, input bit r, output int t);
        bit got;
        got = 0;
        t = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (r ? gnt1_v[k] : gnt0_v[k]) begin
                got = 1;
                t = cyc_cnt;
                break;
            end
        end
        chk("gnt_timeout", k, got, 1);
    endtask

    task automatic wait_done(input int k, output int t);
        bit got;
        got = 0;
        t = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done_v[k]) begin
                got = 1;
                t = cyc_cnt;
                break;
            end
        end
        chk("done_timeout", k, got, 1);
    endtask

    task automatic set_op(input int k, input bit r, input logic [15:0] a, input logic [15:0] b, input logic c);
        if (r) begin
            a1_v[k] = a; b1_v[k] = b; c1_v[k] = c;
        end else begin
            a0_v[k] = a; b0_v[k] = b; c0_v[k] = c;
        end
    endtask

    // One request/complete cycle; operands are scrambled right after the grant edge.
    task automatic do_op(input int k, input bit r, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic [15:0] es, input logic eco, input int lat);
        int tg, td;
        @(posedge clk); #1;
        set_op(k, r, a, b, c);
        if (r) req1_v[k] = 1'b1; else req0_v[k] = 1'b1;
        wait_gnt(k, r, tg);
        @(posedge clk); #1;
        if (r) req1_v[k] = 1'b0; else req0_v[k] = 1'b0;
        set_op(k, r, ~a, ~b, ~c);
        wait_done(k, td);
        chk("latency", k, td - tg, lat);
        chk("lit_s",   k, s_of(k), es);
        chk("lit_cout", k, cout_v[k], eco);
        chk("lit_id",  k, id_v[k], r);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc_cnt);
        $fatal(1, "timeout");
    end

    initial begin
        int tg, td, tg2, t_rel, n, nd;
        int gid[4], gcy[4];
        req0_v = '0; req1_v = '0; c0_v = '0; c1_v = '0;
        for (int k = 0; k < 2; k++) begin
            a0_v[k] = '0; b0_v[k] = '0; a1_v[k] = '0; b1_v[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s", 0, s_a, 0);
        chk("rst_busy", 0, busy_v[0], 0);
        chk("rst_done", 0, done_v[0], 0);
        rst = 1'b0;

        do_op(0, 0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 5);
        do_op(0, 0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 5);
        do_op(0, 1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 5);
        do_op(0, 0, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 5);

        // Both requesters held from reset: strict alternation starting with 0.
        @(posedge clk); #1;
        rst = 1'b1;
        req0_v[0] = 1'b1; req1_v[0] = 1'b1;
        set_op(0, 0, 16'h0010, 16'h0020, 1'b0);
        set_op(0, 1, 16'h0100, 16'h0200, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        t_rel = cyc_cnt;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (gnt0_v[0] | gnt1_v[0]) begin
                gid[n] = gnt1_v[0] ? 1 : 0;
                gcy[n] = cyc_cnt;
                n++;
            end
        end
        chk("rr_count", 0, n, 4);
        @(posedge clk); #1;
        req0_v[0] = 1'b0; req1_v[0] = 1'b0;
        if (n == 4) begin
            chk("rr_first_cycle", 0, gcy[0] - t_rel, 0);
            for (int i = 0; i < 4; i++) chk("rr_order", 0, gid[i], i % 2);
            for (int i = 1; i < 4; i++) chk("rr_spacing", 0, gcy[i] - gcy[i-1], 6);
        end
        wait_done(0, td);
        chk("rr_last_s", 0, s_a, 16'h0301);
        chk("rr_last_id", 0, id_v[0], 1);

        // Late req1 and an operand change during RUN.
        @(posedge clk); #1;
        set_op(0, 0, 16'h0123, 16'h0456, 1'b1);
        req0_v[0] = 1'b1;
        wait_gnt(0, 0, tg);
        @(posedge clk); #1;
        req0_v[0] = 1'b0;
        @(posedge clk); #1;
        set_op(0, 1, 16'h1111, 16'h2222, 1'b0);
        req1_v[0] = 1'b1;
        a0_v[0] = 16'hFFFF;
        wait_done(0, td);
        chk("late_lat", 0, td - tg, 5);
        chk("late_s0", 0, s_a, 16'h057A);
        chk("late_id0", 0, id_v[0], 0);
        wait_gnt(0, 1, tg2);
        chk("late_gnt1_gap", 0, tg2 - tg, 6);
        @(posedge clk); #1;
        req1_v[0] = 1'b0;
        wait_done(0, td);
        chk("late_s1", 0, s_a, 16'h3333);
        chk("late_id1", 0, id_v[0], 1);

        // Reset in the second RUN cycle aborts the operation.
        @(posedge clk); #1;
        set_op(0, 0, 16'h00AA, 16'h0011, 1'b0);
        req0_v[0] = 1'b1;
        wait_gnt(0, 0, tg);
        @(posedge clk); #1;
        req0_v[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_s", 0, s_a, 0);
        chk("abort_cout", 0, cout_v[0], 0);
        chk("abort_busy", 0, busy_v[0], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_v[0]) nd++;
        end
        chk("abort_no_done", 0, nd, 0);
        do_op(0, 1, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 5);

        // Single-nibble instance.
        do_op(1, 0, 16'h0009, 16'h0009, 1'b0, 16'h0002, 1'b1, 2);
        do_op(1, 1, 16'h000D, 16'h0009, 1'b1, 16'h0007, 1'b1, 2);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
